// File: rtl/calc_pkg.sv
// Shared calculator definitions: key token codes, ALU opcodes and controller states.
// Also used by the ALU and the button scanner.
package calc_pkg;

    localparam logic [4:0] TOK_AC  = 5'b10000;
    localparam logic [4:0] TOK_ADD = 5'b10001;
    localparam logic [4:0] TOK_SUB = 5'b10010;
    localparam logic [4:0] TOK_MUL = 5'b10011;
    localparam logic [4:0] TOK_DIV = 5'b10100;
    localparam logic [4:0] TOK_EQ  = 5'b10101;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_OP_PEND,
        ST_ENTRY_B,
        ST_RESULT,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_ERROR
    } ctrl_state_e;

    function automatic logic tok_is_digit(input logic [4:0] tok);
        return !tok[4];
    endfunction

    function automatic logic tok_is_arith(input logic [4:0] tok);
        return (tok >= TOK_ADD) && (tok <= TOK_DIV);
    endfunction

    // Arithmetic tokens are consecutive codes, so the opcode is the offset from TOK_ADD.
    function automatic alu_op_e tok_to_op(input logic [4:0] tok);
        logic [2:0] idx;
        idx = tok[2:0] - 3'd1;
        return alu_op_e'(idx[1:0]);
    endfunction

endpackage

// File: rtl/calc_operand_reg.sv
// WIDTH-bit operand register with clear, parallel load and hex digit shift-in.
// Priority: clear > load > shift.
module calc_operand_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic [3:0]       digit_i,
    output logic [WIDTH-1:0] val_o
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (clr_i) begin
            val_d = '0;
        end else if (load_i) begin
            val_d = load_val_i;
        end else if (shift_i) begin
            val_d = {val_q[WIDTH-5:0], digit_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencer: assembles hex operands from key tokens, issues ALU requests
// and drives the display value / error flag.
//
// state       | meaning
// ENTRY_A     | typing the first operand (accumulator)
// OP_PEND     | operator chosen, waiting for first digit of B
// ENTRY_B     | typing the second operand
// RESULT      | last result shown; digit starts a new entry
// ISSUE       | ALU request held until accepted
// WAIT_RES    | waiting for the ALU result
// ERROR       | ALU reported an error; only AC leaves
module calc_controller
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_tok_data,
    input  logic             i_tok_valid,
    output logic             o_tok_ready,
    output logic             o_alu_valid,
    input  logic             i_alu_ready,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    input  logic             i_res_valid,
    output logic             o_res_ready,
    input  logic [WIDTH-1:0] i_res_data,
    input  logic             i_res_err,
    output logic [WIDTH-1:0] o_disp_value,
    output logic             o_disp_err,
    output logic             o_disp_update
);

    ctrl_state_e      state_q, state_d;
    alu_op_e          pend_op_q, pend_op_d;
    alu_op_e          chain_op_q, chain_op_d;
    logic             chain_q, chain_d;
    logic [WIDTH-1:0] disp_last_q;
    logic             err_last_q;

    logic             a_clr, a_load, a_shift;
    logic [WIDTH-1:0] a_load_val;
    logic             b_clr, b_load, b_shift;
    logic [WIDTH-1:0] a_val, b_val;

    logic             tok_fire;
    logic             is_digit, is_arith, is_eq, is_ac;
    logic [WIDTH-1:0] digit_ext;

    assign tok_fire  = i_tok_valid && o_tok_ready;
    assign is_digit  = tok_is_digit(i_tok_data);
    assign is_arith  = tok_is_arith(i_tok_data);
    assign is_eq     = (i_tok_data == TOK_EQ);
    assign is_ac     = (i_tok_data == TOK_AC);
    assign digit_ext = {{(WIDTH-4){1'b0}}, i_tok_data[3:0]};

    always_comb begin
        state_d    = state_q;
        pend_op_d  = pend_op_q;
        chain_op_d = chain_op_q;
        chain_d    = chain_q;
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_load_val = digit_ext;
        a_shift    = 1'b0;
        b_clr      = 1'b0;
        b_load     = 1'b0;
        b_shift    = 1'b0;

        if (tok_fire && is_ac) begin
            a_clr   = 1'b1;
            b_clr   = 1'b1;
            state_d = ST_ENTRY_A;
        end else begin
            unique case (state_q)
                ST_ENTRY_A: begin
                    if (tok_fire && is_digit) begin
                        a_shift = 1'b1;
                    end else if (tok_fire && is_arith) begin
                        pend_op_d = tok_to_op(i_tok_data);
                        state_d   = ST_OP_PEND;
                    end
                end
                ST_OP_PEND: begin
                    if (tok_fire && is_arith) begin
                        pend_op_d = tok_to_op(i_tok_data);
                    end else if (tok_fire && is_digit) begin
                        b_load  = 1'b1;
                        state_d = ST_ENTRY_B;
                    end
                end
                ST_ENTRY_B: begin
                    if (tok_fire && is_digit) begin
                        b_shift = 1'b1;
                    end else if (tok_fire && is_eq) begin
                        chain_d = 1'b0;
                        state_d = ST_ISSUE;
                    end else if (tok_fire && is_arith) begin
                        chain_op_d = tok_to_op(i_tok_data);
                        chain_d    = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
                ST_RESULT: begin
                    if (tok_fire && is_digit) begin
                        a_load  = 1'b1;
                        state_d = ST_ENTRY_A;
                    end else if (tok_fire && is_arith) begin
                        pend_op_d = tok_to_op(i_tok_data);
                        state_d   = ST_OP_PEND;
                    end
                end
                ST_ISSUE: begin
                    if (i_alu_ready) begin
                        state_d = ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (i_res_valid) begin
                        if (i_res_err) begin
                            state_d = ST_ERROR;
                        end else begin
                            a_load     = 1'b1;
                            a_load_val = i_res_data;
                            if (chain_q) begin
                                pend_op_d = chain_op_q;
                                state_d   = ST_OP_PEND;
                            end else begin
                                state_d = ST_RESULT;
                            end
                        end
                    end
                end
                ST_ERROR: begin
                end
                default: begin
                    state_d = ST_ENTRY_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ENTRY_A;
            pend_op_q   <= ALU_ADD;
            chain_op_q  <= ALU_ADD;
            chain_q     <= 1'b0;
            disp_last_q <= '0;
            err_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_op_q   <= pend_op_d;
            chain_op_q  <= chain_op_d;
            chain_q     <= chain_d;
            disp_last_q <= o_disp_value;
            err_last_q  <= o_disp_err;
        end
    end

    calc_operand_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (a_clr),
        .load_i     (a_load),
        .load_val_i (a_load_val),
        .shift_i    (a_shift),
        .digit_i    (i_tok_data[3:0]),
        .val_o      (a_val)
    );

    calc_operand_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clr_i      (b_clr),
        .clk        (clk),
        .rst        (rst),
        .load_i     (b_load),
        .load_val_i (digit_ext),
        .shift_i    (b_shift),
        .digit_i    (i_tok_data[3:0]),
        .val_o      (b_val)
    );

    assign o_tok_ready  = (state_q != ST_ISSUE) && (state_q != ST_WAIT_RES);
    assign o_alu_valid  = (state_q == ST_ISSUE);
    assign o_res_ready  = (state_q == ST_WAIT_RES);
    assign o_alu_a      = a_val;
    assign o_alu_b      = b_val;
    assign o_alu_op     = pend_op_q;
    assign o_disp_value = (state_q == ST_ENTRY_B) ? b_val : a_val;
    assign o_disp_err   = (state_q == ST_ERROR);
    // Pulse whenever the shown value or flag differs from what was shown last cycle.
    assign o_disp_update = (o_disp_value != disp_last_q) || (o_disp_err != err_last_q);

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: directed scenarios followed by random
// key sequences, compared against a calculator reference model; the bench plays the ALU.
module tb_calc_controller;
    import calc_pkg::*;

    localparam int W = 16;
    localparam int M_A = 0, M_OP = 1, M_B = 2, M_RES = 3, M_ERR = 4, M_BUSY = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   i_tok_data;
    logic         i_tok_valid;
    logic         o_tok_ready;
    logic         o_alu_valid;
    logic         i_alu_ready;
    logic [W-1:0] o_alu_a, o_alu_b;
    logic [1:0]   o_alu_op;
    logic         i_res_valid;
    logic         o_res_ready;
    logic [W-1:0] i_res_data;
    logic         i_res_err;
    logic [W-1:0] o_disp_value;
    logic         o_disp_err;
    logic         o_disp_update;

    calc_controller #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_tok_data    (i_tok_data),
        .i_tok_valid   (i_tok_valid),
        .o_tok_ready   (o_tok_ready),
        .o_alu_valid   (o_alu_valid),
        .i_alu_ready   (i_alu_ready),
        .o_alu_a       (o_alu_a),
        .o_alu_b       (o_alu_b),
        .o_alu_op      (o_alu_op),
        .i_res_valid   (i_res_valid),
        .o_res_ready   (o_res_ready),
        .i_res_data    (i_res_data),
        .i_res_err     (i_res_err),
        .o_disp_value  (o_disp_value),
        .o_disp_err    (o_disp_err),
        .o_disp_update (o_disp_update)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int req_count = 0;

    // Reference calculator state
    logic [W-1:0] m_a, m_b;
    int           m_mode;
    logic [1:0]   m_pend, m_cop;
    bit           m_chain;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_disp();
        return (m_mode == M_B) ? m_b : m_a;
    endfunction

    task automatic model_reset();
        m_a = '0; m_b = '0; m_mode = M_A; m_pend = 2'b00; m_cop = 2'b00; m_chain = 1'b0;
    endtask

    task automatic alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                           output logic [W-1:0] res, output bit err);
        int unsigned r;
        err = 1'b0;
        case (op)
            2'b00: r = int'(a) + int'(b);
            2'b01: r = int'(a) - int'(b);
            2'b10: r = int'(a) * int'(b);
            default: begin
                if (b == 0) begin err = 1'b1; r = 0; end
                else r = int'(a) / int'(b);
            end
        endcase
        res = r[W-1:0];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tok_ready"}, o_tok_ready, 1);
        check({tag, "_alu_valid"}, o_alu_valid, 0);
        check({tag, "_res_ready"}, o_res_ready, 0);
        check({tag, "_alu_a"}, o_alu_a, 0);
        check({tag, "_alu_b"}, o_alu_b, 0);
        check({tag, "_alu_op"}, o_alu_op, 0);
        check({tag, "_disp_value"}, o_disp_value, 0);
        check({tag, "_disp_err"}, o_disp_err, 0);
        check({tag, "_disp_update"}, o_disp_update, 0);
    endtask

    // Presents a token and returns at the falling edge of the cycle after acceptance.
    task automatic send_tok(input logic [4:0] t);
        bit done;
        done = 1'b0;
        @(negedge clk);
        i_tok_data  = t;
        i_tok_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (o_tok_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 i_tok_valid = 1'b0;
        check("tok_accept", {31'd0, done}, 1);
        @(negedge clk);
    endtask

    task automatic apply_tok(input logic [4:0] t, output bit issue);
        logic [W-1:0] pv;
        bit           pe;
        logic [3:0]   d;
        logic [4:0]   k;
        pv    = m_disp();
        pe    = (m_mode == M_ERR);
        issue = 1'b0;
        d     = t[3:0];
        k     = t - 5'h11;
        if (t == 5'h10) begin
            m_a = '0; m_b = '0; m_mode = M_A;
        end else if (t > 5'h15 || m_mode == M_ERR) begin
            // dropped
        end else if (!t[4]) begin
            case (m_mode)
                M_A:   m_a = {m_a[W-5:0], d};
                M_OP:  begin m_b = {{(W-4){1'b0}}, d}; m_mode = M_B; end
                M_B:   m_b = {m_b[W-5:0], d};
                M_RES: begin m_a = {{(W-4){1'b0}}, d}; m_mode = M_A; end
                default: ;
            endcase
        end else if (t == 5'h15) begin
            if (m_mode == M_B) begin m_chain = 1'b0; issue = 1'b1; end
        end else begin
            if (m_mode == M_B) begin
                m_cop = k[1:0]; m_chain = 1'b1; issue = 1'b1;
            end else begin
                m_pend = k[1:0]; m_mode = M_OP;
            end
        end
        if (issue) m_mode = M_BUSY;
        send_tok(t);
        check("disp_value", o_disp_value, m_disp());
        check("disp_err", o_disp_err, (m_mode == M_ERR));
        check("disp_update", o_disp_update, (pv != m_disp()) || (pe != (m_mode == M_ERR)));
        check("alu_valid", o_alu_valid, issue);
        if (issue) begin
            check("req_a", o_alu_a, m_a);
            check("req_b", o_alu_b, m_b);
            check("req_op", o_alu_op, m_pend);
        end
    endtask

    // Acts as the ALU for one outstanding request, starting in the cycle after issue.
    task automatic service(input int rdly, input int sdly, input bit junk);
        logic [W-1:0] exp_res, pv;
        bit           exp_err;
        alu_ref(m_a, m_b, m_pend, exp_res, exp_err);
        req_count++;
        for (int i = 0; i < rdly; i++) begin
            check("hold_valid", o_alu_valid, 1);
            check("hold_a", o_alu_a, m_a);
            check("hold_b", o_alu_b, m_b);
            check("hold_op", o_alu_op, m_pend);
            check("hold_tok_ready", o_tok_ready, 0);
            @(negedge clk);
        end
        i_alu_ready = 1'b1;
        if (junk) begin
            i_res_valid = 1'b1;
            i_res_data  = ~exp_res;
        end
        @(posedge clk);
        #1 i_alu_ready = 1'b0;
        i_res_valid = 1'b0;
        @(negedge clk);
        check("res_ready", o_res_ready, 1);
        check("valid_dropped", o_alu_valid, 0);
        for (int i = 0; i < sdly; i++) @(negedge clk);
        i_res_valid = 1'b1;
        i_res_data  = exp_res;
        i_res_err   = exp_err;
        @(posedge clk);
        #1 i_res_valid = 1'b0;
        i_res_err = 1'b0;
        pv = m_a;
        if (exp_err) begin
            m_mode = M_ERR;
        end else begin
            m_a = exp_res;
            if (m_chain) begin m_pend = m_cop; m_mode = M_OP; end
            else m_mode = M_RES;
        end
        @(negedge clk);
        check("res_disp_value", o_disp_value, m_disp());
        check("res_disp_err", o_disp_err, exp_err);
        check("res_disp_update", o_disp_update, (pv != m_a) || exp_err);
        check("res_tok_ready", o_tok_ready, 1);
        check("res_ready_low", o_res_ready, 0);
    endtask

    task automatic play(input logic [4:0] t);
        bit iss;
        apply_tok(t, iss);
        if (iss) service($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        logic [4:0] t;
        int         r;
        bit         iss;

        rst = 1'b1;
        i_tok_data = '0; i_tok_valid = 1'b0; i_alu_ready = 1'b0;
        i_res_valid = 1'b0; i_res_data = '0; i_res_err = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic add
        req_count = 0;
        play(5'h01); play(5'h02); play(TOK_ADD); play(5'h03); play(TOK_EQ);
        check("add_result", o_disp_value, 16'h0015);
        check("add_requests", req_count, 1);

        // Chaining
        play(TOK_AC);
        req_count = 0;
        play(5'h05); play(TOK_MUL); play(5'h04); play(TOK_SUB); play(5'h01); play(TOK_EQ);
        check("chain_result", o_disp_value, 16'h0013);
        check("chain_requests", req_count, 2);

        // Operator replacement
        play(TOK_AC);
        req_count = 0;
        play(5'h09); play(TOK_ADD); play(TOK_SUB); play(TOK_MUL); play(5'h02); play(TOK_EQ);
        check("replace_result", o_disp_value, 16'h0012);
        check("replace_requests", req_count, 1);

        // Digit overflow
        play(TOK_AC);
        play(5'h01); play(5'h02); play(5'h03); play(5'h04); play(5'h05);
        check("overflow_value", o_disp_value, 16'h2345);

        // Divide by zero, then tokens ignored until AC
        play(TOK_AC);
        play(5'h07); play(TOK_DIV); play(5'h00); play(TOK_EQ);
        check("div0_err", o_disp_err, 1);
        play(5'h03); play(TOK_ADD); play(TOK_EQ); play(5'h1F);
        check("err_sticky", o_disp_err, 1);
        play(TOK_AC);
        check("ac_err", o_disp_err, 0);
        check("ac_value", o_disp_value, 16'h0000);

        // Backpressure with a held token, then reset while waiting for the result
        play(5'h01); play(TOK_ADD); play(5'h02);
        apply_tok(TOK_EQ, iss);
        check("bp_issue", {31'd0, iss}, 1);
        i_tok_data  = 5'h07;
        i_tok_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", o_alu_valid, 1);
            check("bp_a", o_alu_a, 16'h0001);
            check("bp_b", o_alu_b, 16'h0002);
            check("bp_op", o_alu_op, 2'b00);
            check("bp_tok_ready", o_tok_ready, 0);
            @(negedge clk);
        end
        i_tok_valid = 1'b0;
        i_alu_ready = 1'b1;
        @(posedge clk);
        #1 i_alu_ready = 1'b0;
        @(negedge clk);
        check("bp_res_ready", o_res_ready, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midwait_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        i_res_valid = 1'b1;
        i_res_data  = 16'hBEEF;
        @(posedge clk);
        #1 i_res_valid = 1'b0;
        @(negedge clk);
        check("late_res_value", o_disp_value, 16'h0000);
        check("late_res_update", o_disp_update, 0);
        check("late_res_tok_ready", o_tok_ready, 1);

        // Random key sequences
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      t = 5'($urandom_range(0, 15));
            else if (r < 80) t = 5'($urandom_range(17, 20));
            else if (r < 92) t = TOK_EQ;
            else if (r < 96) t = TOK_AC;
            else             t = 5'($urandom_range(22, 31));
            play(t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
